// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - mask-driven select/enable scan controller feeding a 3-to-8 decoder
// Optional SCAN_BLANK_EN inserts one E-low cycle before every line change.
module decoder_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [7:0] mask,
  output logic [2:0] A,
  output logic       E,
  output logic       busy,
  output logic       done,
  output logic       frame
);

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL} state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mode_q, mode_d;
  logic [2:0] a_d;
  logic       e_d, busy_d, done_d, frame_d;

  logic [2:0] low_idx, up_idx;
  logic       up_found;

  // Descending walk so the lowest qualifying index is the one left standing.
  always_comb begin
    low_idx  = 3'd0;
    up_idx   = 3'd0;
    up_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        low_idx = 3'(i);
        if (3'(i) > A) begin
          up_idx   = 3'(i);
          up_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      mode_q  <= 1'b0;
      A       <= 3'd0;
      E       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      frame   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      A       <= a_d;
      E       <= e_d;
      busy    <= busy_d;
      done    <= done_d;
      frame   <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = A;
    e_d     = E;
    busy_d  = busy;
    done_d  = 1'b0;
    frame_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (|mask) begin
            mode_d  = mode;
            a_d     = low_idx;
            e_d     = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = RELOAD;
            state_d = S_DWELL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (up_found || (!mode_q && |mask)) begin
          // A wrap to the lowest enabled line is the only advance that flags a frame.
          a_d     = up_found ? up_idx : low_idx;
          frame_d = !up_found;
`ifdef SCAN_BLANK_EN
          e_d     = 1'b0;
          state_d = S_BLANK;
`else
          cnt_d   = RELOAD;
`endif
        end else begin
          e_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          e_d     = 1'b1;
          cnt_d   = RELOAD;
          state_d = S_DWELL;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - scoreboard bench for decoder_scan_ctrl (line, done and frame events with cycle stamps)
module tb_decoder_scan_ctrl;

`ifdef SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int DW = 4;
  localparam int P  = DW + BLK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [2:0] a;
  logic       e, busy, done, frame;

  decoder_scan_ctrl #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .A(a), .E(e), .busy(busy), .done(done), .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val; int cyc;} ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;
  logic       e_prev = 1'b0;
  logic [2:0] a_prev = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind 0 = new line shown (val = A), 1 = done (val = busy), 2 = frame
  always @(negedge clk) begin
    if (frame) obs_q.push_back('{2, 0, cyc});
    if (e && (!e_prev || a != a_prev)) obs_q.push_back('{0, int'(a), cyc});
    if (done) obs_q.push_back('{1, int'(busy), cyc});
    e_prev <= e;
    a_prev <= a;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic expect_ev(input int kind, input int val, input int off);
    exp_q.push_back('{kind, val, t0 + off});
  endtask

  task automatic start_scan(input logic [7:0] m, input logic md);
    mask  = m;
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic drain(input string tag);
    ev_t o, x;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      x = exp_q.pop_front();
      check({tag, "_kind"}, o.kind, x.kind);
      check({tag, "_val"}, o.val, x.val);
      check({tag, "_cyc"}, o.cyc - t0, x.cyc - t0);
    end
    check({tag, "_unexpected_events"}, obs_q.size(), 0);
    check({tag, "_missing_events"}, exp_q.size(), 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tick(3);
    check("rst_a", int'(a), 0);
    check("rst_e", int'(e), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frame", int'(frame), 0);
    rst_n = 1'b1;
    tick(2);
    drain("idle");

    // Single pass over all lines; a start mid-scan must be ignored.
    t0 = cyc + 1;
    for (int k = 0; k < 8; k++) expect_ev(0, k, k * P);
    expect_ev(1, 0, 7 * P + DW);
    start_scan(8'hFF, 1'b1);
    tick(10);
    mode = 1'b0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(40);
    drain("single");
    check("single_end_e", int'(e), 0);

    // Continuous 2,5,7 with frame on each wrap, then stop mid-dwell on line 2.
    t0 = cyc + 1;
    for (int f = 0; f < 2; f++) begin
      expect_ev(0, 2, 3 * P * f);
      expect_ev(0, 5, 3 * P * f + P);
      expect_ev(0, 7, 3 * P * f + 2 * P);
      expect_ev(2, 0, 3 * P * f + 3 * P - BLK);
    end
    expect_ev(0, 2, 6 * P);
    start_scan(8'b1010_0100, 1'b0);
    tick(6 * P + 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("cont_stop_a", int'(a), 2);
    check("cont_stop_e", int'(e), 0);
    check("cont_stop_busy", int'(busy), 0);
    tick(3);
    drain("cont");

    // Stop while on line 3, then restart from the lowest set bit.
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) expect_ev(0, k, k * P);
    start_scan(8'h0F, 1'b1);
    tick(3 * P + 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_a", int'(a), 3);
    check("stop_e", int'(e), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_done", int'(done), 0);
    tick(2);
    drain("stop");
    t0 = cyc + 1;
    expect_ev(0, 2, 0);
    expect_ev(0, 3, P);
    expect_ev(1, 0, P + DW);
    start_scan(8'h0C, 1'b1);
    tick(P + 8);
    drain("restart");

    // Start with an empty mask: done only, A untouched.
    t0 = cyc + 1;
    expect_ev(1, 0, 0);
    start_scan(8'h00, 1'b1);
    check("empty_done", int'(done), 1);
    check("empty_busy", int'(busy), 0);
    check("empty_e", int'(e), 0);
    check("empty_a", int'(a), 3);
    tick(2);
    check("empty_done_pulse", int'(done), 0);
    drain("empty");

    // Mask cleared mid-line during a continuous scan.
    t0 = cyc + 1;
    expect_ev(0, 0, 0);
    expect_ev(1, 0, DW);
    start_scan(8'h11, 1'b0);
    tick(2);
    mask = 8'h00;
    tick(6);
    check("maskclr_e", int'(e), 0);
    check("maskclr_busy", int'(busy), 0);
    drain("maskclr");

    // Reset while A = 5 aborts without done; a new scan starts cleanly.
    t0 = cyc + 1;
    for (int k = 0; k < 6; k++) expect_ev(0, k, k * P);
    start_scan(8'hFF, 1'b0);
    tick(5 * P + 1);
    check("pre_rst_a", int'(a), 5);
    rst_n = 1'b0;
    tick(1);
    check("midrst_a", int'(a), 0);
    check("midrst_e", int'(e), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    drain("midrst");
    t0 = cyc + 1;
    expect_ev(0, 0, 0);
    expect_ev(1, 0, DW);
    start_scan(8'h01, 1'b1);
    tick(8);
    drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
